// File: rtl/fp32_multiplier.sv
// Single-precision IEEE-754 multiplier with a one-cycle registered result.
// Denormal operands are flushed to zero and results round to nearest-even.
module fp32_multiplier (
  input  logic        control,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        exception
);

  logic        sign;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [22:0] frac_a;
  logic [22:0] frac_b;

  logic        zero_a;
  logic        zero_b;
  logic        inf_a;
  logic        inf_b;
  logic        nan_a;
  logic        nan_b;

  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic [47:0] product;

  logic signed [9:0] exp_sum;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_final;

  logic [23:0] mant_norm;
  logic        guard_bit;
  logic        round_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [24:0] mant_rounded;
  logic [22:0] frac_final;

  logic [31:0] result;
  logic        result_exc;

  assign sign   = A[31] ^ B[31];
  assign exp_a  = A[30:23];
  assign exp_b  = B[30:23];
  assign frac_a = A[22:0];
  assign frac_b = B[22:0];

  assign zero_a = (exp_a == 8'd0);
  assign zero_b = (exp_b == 8'd0);
  assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
  assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);

  assign mant_a  = {1'b1, frac_a};
  assign mant_b  = {1'b1, frac_b};
  assign product = {24'd0, mant_a} * {24'd0, mant_b};

  // Ten signed bits leave headroom for both overflow and underflow detection.
  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

  always_comb begin
    if (product[47]) begin
      mant_norm  = product[47:24];
      guard_bit  = product[23];
      round_bit  = product[22];
      sticky_bit = |product[21:0];
      exp_norm   = exp_sum + 10'sd1;
    end else begin
      mant_norm  = product[46:23];
      guard_bit  = product[22];
      round_bit  = product[21];
      sticky_bit = |product[20:0];
      exp_norm   = exp_sum;
    end
  end

  assign round_up     = guard_bit & (round_bit | sticky_bit | mant_norm[0]);
  assign mant_rounded = {1'b0, mant_norm} + {24'd0, round_up};

  // A carry out of rounding leaves the mantissa at exactly 2.0.
  always_comb begin
    if (mant_rounded[24]) begin
      frac_final = mant_rounded[23:1];
      exp_final  = exp_norm + 10'sd1;
    end else begin
      frac_final = mant_rounded[22:0];
      exp_final  = exp_norm;
    end
  end

  always_comb begin
    result     = {sign, exp_final[7:0], frac_final};
    result_exc = 1'b0;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      result     = 32'h7FC00000;
      result_exc = 1'b1;
    end else if (inf_a || inf_b) begin
      result     = {sign, 8'hFF, 23'd0};
      result_exc = 1'b1;
    end else if (zero_a || zero_b) begin
      result     = {sign, 31'd0};
      result_exc = 1'b0;
    end else if (exp_final >= 10'sd255) begin
      result     = {sign, 8'hFF, 23'd0};
      result_exc = 1'b1;
    end else if (exp_final <= 10'sd0) begin
      result     = {sign, 31'd0};
      result_exc = 1'b0;
    end
  end

  always_ff @(posedge control) begin
    if (reset) begin
      out       <= 32'h00000000;
      exception <= 1'b0;
    end else begin
      out       <= result;
      exception <= result_exc;
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Self-checking bench for fp32_multiplier: directed literal vectors, an
// integer-arithmetic reference model, and a per-cycle scoreboard.
module tb_fp32_multiplier;

  logic        control = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] out;
  logic        exception;

  int checks   = 0;
  int failures = 0;

  logic [32:0] expect_q;
  logic        expect_valid = 1'b0;

  always #5 control = ~control;

  fp32_multiplier dut (
    .control  (control),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .out      (out),
    .exception(exception)
  );

  // Reference product: exact integer product, normalise by locating its
  // leading one, then round the discarded remainder to nearest-even.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              ea, eb, e, msb, shift;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned m, q, r, half;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {1'b1, 32'h7FC00000};
    if (a_inf || b_inf) return {1'b1, s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {1'b0, s, 31'd0};
    m = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    msb = 0;
    for (int i = 0; i < 64; i++) if (m[i]) msb = i;
    shift = msb - 23;
    e     = ea + eb - 127 + (msb - 46);
    q     = m >> shift;
    r     = m - (q << shift);
    half  = 64'd1 << (shift - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), q[22:0]};
  endfunction

  // Scoreboard: predict from the inputs seen at each edge, compare mid-cycle.
  always @(posedge control) begin
    if (reset) begin
      expect_q     <= 33'd0;
      expect_valid <= 1'b1;
    end else if (expect_valid) begin
      expect_q <= ref_mul(A, B);
    end
  end

  always @(negedge control) begin
    if (expect_valid) begin
      checks++;
      if ({exception, out} !== expect_q) begin
        failures++;
        $display("[TB] FAIL scoreboard @%0t: out=%h exception=%b, expected out=%h exception=%b",
                 $time, out, exception, expect_q[31:0], expect_q[32]);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] want_out, input logic want_exc);
    checks++;
    if (out !== want_out || exception !== want_exc) begin
      failures++;
      $display("[TB] FAIL %s: out=%h exception=%b, expected out=%h exception=%b",
               name, out, exception, want_out, want_exc);
    end
  endtask

  task automatic pin_model(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [32:0] want);
    logic [32:0] got;
    got = ref_mul(a, b);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL model_%s: model=%h, expected %h", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] want_out, input logic want_exc);
    @(negedge control);
    A = a;
    B = b;
    @(posedge control);
    #1;
    check_output(name, want_out, want_exc);
  endtask

  initial begin
    logic [32:0] rnd_expect;
    logic [31:0] ra, rb;
    logic [7:0]  ea, eb;

    reset = 1'b1;
    A     = 32'h40400000;
    B     = 32'h40400000;

    pin_model("one",        32'h3F800000, 32'h3F800000, {1'b0, 32'h3F800000});
    pin_model("six",        32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
    pin_model("tie_up",     32'h3F800001, 32'h3FC00000, {1'b0, 32'h3FC00002});
    pin_model("tie_even",   32'h3F800003, 32'h3FC00000, {1'b0, 32'h3FC00004});
    pin_model("carry",      32'h3F800001, 32'h3FFFFFFE, {1'b0, 32'h40000000});
    pin_model("inf_zero",   32'h7F800000, 32'h00000000, {1'b1, 32'h7FC00000});
    pin_model("overflow",   32'h7F000000, 32'h7F000000, {1'b1, 32'h7F800000});
    pin_model("underflow",  32'h80800000, 32'h00800000, {1'b0, 32'h80000000});

    repeat (2) @(posedge control);
    #1;
    check_output("reset", 32'h00000000, 1'b0);
    reset = 1'b0;

    apply_stimulus("one_x_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
    apply_stimulus("quarter_x2", 32'h3E800000, 32'h40000000, 32'h3F000000, 1'b0);
    apply_stimulus("two_x3",     32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    apply_stimulus("comm_ab",    32'h3FA00000, 32'h40800000, 32'h40A00000, 1'b0);
    apply_stimulus("comm_ba",    32'h40800000, 32'h3FA00000, 32'h40A00000, 1'b0);
    apply_stimulus("inf_pos",    32'h7F800000, 32'h3F9E46F1, 32'h7F800000, 1'b1);
    apply_stimulus("inf_neg",    32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1);
    apply_stimulus("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1);
    apply_stimulus("nan_in",     32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b1);
    apply_stimulus("zero_neg",   32'h00000000, 32'hBF800000, 32'h80000000, 1'b0);
    apply_stimulus("denorm",     32'h00400000, 32'h3F800000, 32'h00000000, 1'b0);
    apply_stimulus("overflow",   32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);
    apply_stimulus("underflow",  32'h00800000, 32'h00800000, 32'h00000000, 1'b0);
    apply_stimulus("tie_up",     32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0);
    apply_stimulus("tie_even",   32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0);
    apply_stimulus("carry",      32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 1'b0);
    apply_stimulus("near_two",   32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0);

    rnd_expect = ref_mul(32'h3FD3CD36, 32'h3F9E46F1);
    apply_stimulus("round_ref",  32'h3FD3CD36, 32'h3F9E46F1, rnd_expect[31:0], rnd_expect[32]);

    // Reset must win over a live computation.
    @(negedge control);
    reset = 1'b1;
    A     = 32'h40000000;
    B     = 32'h40400000;
    @(posedge control);
    #1;
    check_output("reset_override", 32'h00000000, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      if (i % 4 == 0) begin
        ea = 8'($urandom_range(254, 1));
        eb = 8'($urandom_range(254, 1));
      end else begin
        ea = 8'($urandom_range(190, 64));
        eb = 8'($urandom_range(190, 64));
      end
      ra = {1'($urandom), ea, 23'($urandom)};
      rb = {1'($urandom), eb, 23'($urandom)};
      @(negedge control);
      A = ra;
      B = rb;
      @(negedge control);
      A = rb;
      B = ra;
    end

    repeat (2) @(posedge control);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
